ftdi_burst_writer: RTL
======================

# ftdi_burst_writer

Memory-clock-domain command engine that drains 32-bit (parametrisable) words from the FTDI clock-crossing FIFO, parses block-write commands and issues fixed-length burst writes to the SDRAM controller. It is the generalised successor of the single-mode FTDI copy engine: configurable data, address and length widths and burst size, plus a FILL mode, length checking and status outputs. It sits between the FIFO read port and the memory-controller write port.

## Interface
- DW, 32: data word width; multiple of 8.
- AW, 25: memory byte-address width.
- LEN_W, 8: command length field width, in words.
- BURST, 4: words per memory request; power of 2, ≥2.
- LVL_W, 4: FIFO fill-level width.
- mem_clk  in  1  clock; all logic is on its rising edge.
- ft_reset  in  1  reset ft_reset, asynchronous, active-high; clock mem_clk.
- fifo_empty  in  1  FIFO read side empty.
- fifo_data  in  DW  show-ahead head word; valid when !fifo_empty.
- fifo_level  in  LVL_W  words currently readable.
- fifo_rd  out  1  pop head word this cycle.
- mem_idle  in  1  controller can accept a request.
- mem_ack  in  1  one-cycle pulse: request accepted.
- mem_data_next  in  1  current mem_wr_data consumed this cycle.
- mem_wr_req  out  1  write request.
- mem_wr_addr  out  AW  byte address of current burst.
- mem_wr_data  out  DW  write data.
- busy  out  1  high in every state except IDLE.
- cmd_done  out  1  one-cycle pulse, command completed.
- cmd_err  out  1  one-cycle pulse, command rejected.

## Operation
- Command = header word, address word, then payload. Header: [LEN_W-1:0] len in words, [LEN_W+7:LEN_W] opcode. Address word: low AW bits, byte address.
- Opcode 0x00 COPY: len payload words from FIFO. 0x01 FILL: one pattern word, written len times. Other opcodes: reject.
- len==0: valid no-op; cmd_done after ADDR, no memory traffic. len not a multiple of BURST, or unknown opcode: pop header only, pulse cmd_err, return to IDLE; the next word is parsed as a new header.
- States: IDLE -(!fifo_empty)-> HDR (pop, latch len/opcode) -> ADDR (wait !fifo_empty, pop, latch addr) -> PAT (FILL only; wait !fifo_empty, pop, latch pattern) -> REQ -> ACK -> DATA -> REQ or DONE -> IDLE.
- REQ: assert mem_wr_req when mem_idle and, for COPY, fifo_level ≥ BURST. Hold mem_wr_req until mem_ack; then ACK.
- DATA: mem_wr_data = fifo_data (COPY) or pattern (FILL). On mem_data_next: fifo_rd=1 (COPY only), increment burst word counter. After BURST beats, addr += BURST·DW/8, remaining -= BURST; remaining==0 -> DONE, else REQ.
- Address arithmetic wraps modulo 2^AW without error.
- mem_wr_data is 0 outside ACK/DATA.

## Timing
- Reset: all state to IDLE, mem_wr_req=0, mem_wr_addr=0, fifo_rd=0, busy=0, cmd_done=0, cmd_err=0, counters 0. Reset mid-burst abandons the command; no partial-burst completion; FIFO contents not flushed here.
- fifo_rd is combinational: HDR, ADDR and PAT pop in their first cycle with !fifo_empty; DATA pops in the same cycle as mem_data_next. Never pop while fifo_empty.
- mem_wr_req registered; earliest assertion 1 cycle after entering REQ; deasserted the cycle after mem_ack.
- mem_ack together with mem_data_next in the same cycle: both honoured, first beat counted.
- mem_data_next with COPY and fifo_empty: protocol violation, prevented by the level check in REQ.
- cmd_done asserted in DONE; busy falls the following cycle. Minimum header-to-first-request latency for COPY: 3 cycles after the header is visible.

## Structure
- Shared package ftdi_pkg: opcode constants OP_COPY/OP_FILL, state encoding, header field positions.
- One sub-module, ftdi_burst_counter: remaining-length and in-burst beat counters with terminal flags.

## Test plan
- COPY len=8, addr=0x10, data 0..7, BURST=4 -> two requests at 0x10 and 0x20, data 0..7 in order, one cmd_done, 10 pops.
- FILL len=4, addr=0x100, pattern 0xA5A5A5A5 -> one burst of four 0xA5A5A5A5, 3 pops, no pops during DATA.
- Header opcode 0x07, then a valid COPY len=4 -> cmd_err pulse, no mem_wr_req; second command completes.
- len=6 with BURST=4 -> cmd_err, only the header popped; len=0 -> cmd_done, no request.
- COPY len=4 with fifo_level held at 3 -> mem_wr_req stays low until level reaches 4; mem_idle low delays the request.
- ft_reset during the second beat of a burst -> all outputs 0 on the same edge, IDLE; a new command afterwards completes correctly.

Source files
------------

// File: rtl/ftdi_pkg.sv
// Shared definitions for the FTDI burst-write command engine.
//   - Opcode constants for the command header.
//   - Header field positions (length field at the bottom, 8-bit opcode above it).
//   - FSM state encoding.
package ftdi_pkg;

    localparam int OP_W        = 8;
    localparam int HDR_LEN_LSB = 0;

    localparam logic [OP_W-1:0] OP_COPY = 8'h00;
    localparam logic [OP_W-1:0] OP_FILL = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_ADDR = 3'd2,
        S_PAT  = 3'd3,
        S_REQ  = 3'd4,
        S_ACK  = 3'd5,
        S_DATA = 3'd6,
        S_DONE = 3'd7
    } state_e;

    function automatic logic opcode_valid(input logic [OP_W-1:0] op);
        return (op == OP_COPY) || (op == OP_FILL);
    endfunction

endpackage

// File: rtl/ftdi_burst_counter.sv
// Remaining-length and in-burst beat counters for the burst writer.
//   mem_clk, ft_reset : clock, asynchronous active-high reset
//   load_i, len_i     : load a new command length (words), clears the beat count
//   beat_i            : one data word consumed by the memory controller
//   last_beat_o       : current beat is the final beat of the burst
//   last_burst_o      : current burst is the final burst of the command
//   rem_zero_o        : nothing left to write (len==0 command)
module ftdi_burst_counter #(
    parameter int LEN_W = 8,
    parameter int BURST = 4
) (
    input  logic             mem_clk,
    input  logic             ft_reset,
    input  logic             load_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             beat_i,
    output logic             last_beat_o,
    output logic             last_burst_o,
    output logic             rem_zero_o
);

    localparam int               BEAT_W    = $clog2(BURST);
    localparam logic [BEAT_W-1:0] BEAT_MAX  = BEAT_W'(BURST - 1);
    localparam logic [LEN_W-1:0]  BURST_LEN = LEN_W'(BURST);

    logic [LEN_W-1:0]  remaining_q;
    logic [BEAT_W-1:0] beat_q;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of block ordering.
    always_ff @(posedge mem_clk or posedge ft_reset) begin
        if (ft_reset) begin
            remaining_q <= '0;
            beat_q      <= '0;
        end else if (load_i) begin
            remaining_q <= len_i;
            beat_q      <= '0;
        end else if (beat_i) begin
            if (beat_q == BEAT_MAX) begin
                beat_q      <= '0;
                remaining_q <= remaining_q - BURST_LEN;
            end else begin
                beat_q <= beat_q + BEAT_W'(1);
            end
        end
    end

    assign last_beat_o  = (beat_q == BEAT_MAX);
    // Accepted lengths are multiples of BURST, so equality marks the final burst.
    assign last_burst_o = (remaining_q == BURST_LEN);
    assign rem_zero_o   = (remaining_q == '0);

endmodule

// File: rtl/ftdi_burst_writer.sv
// Command engine between the FTDI clock-crossing FIFO and the SDRAM write port.
// Parses header/address(/pattern) words and issues BURST-word write bursts.
//   mem_clk, ft_reset          : clock, asynchronous active-high reset
//   fifo_empty/data/level, fifo_rd : show-ahead FIFO read port (fifo_rd pops)
//   mem_idle, mem_ack, mem_data_next : controller handshake inputs
//   mem_wr_req/addr/data       : write request, burst byte address, write data
//   busy, cmd_done, cmd_err    : status (done/err are one-cycle pulses)
module ftdi_burst_writer
    import ftdi_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 25,
    parameter int LEN_W = 8,
    parameter int BURST = 4,
    parameter int LVL_W = 4
) (
    input  logic             mem_clk,
    input  logic             ft_reset,
    input  logic             fifo_empty,
    input  logic [DW-1:0]    fifo_data,
    input  logic [LVL_W-1:0] fifo_level,
    output logic             fifo_rd,
    input  logic             mem_idle,
    input  logic             mem_ack,
    input  logic             mem_data_next,
    output logic             mem_wr_req,
    output logic [AW-1:0]    mem_wr_addr,
    output logic [DW-1:0]    mem_wr_data,
    output logic             busy,
    output logic             cmd_done,
    output logic             cmd_err
);

    localparam int            BEAT_W      = $clog2(BURST);
    localparam logic [AW-1:0] BURST_BYTES = AW'(BURST * DW / 8);

    state_e          state_q;
    logic            fill_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   pat_q;
    logic            req_q;
    logic            err_q;

    logic [LEN_W-1:0] hdr_len;
    logic [OP_W-1:0]  hdr_op;
    logic             len_aligned;
    logic             level_ok;
    logic             beat;
    logic             last_beat;
    logic             last_burst;
    logic             rem_zero;

    assign hdr_len     = fifo_data[HDR_LEN_LSB +: LEN_W];
    assign hdr_op      = fifo_data[LEN_W +: OP_W];
    assign len_aligned = (hdr_len[BEAT_W-1:0] == '0);
    // FILL needs no FIFO data during the burst; COPY must hold a full burst
    // so mem_data_next can never hit an empty FIFO.
    assign level_ok    = fill_q || (int'(fifo_level) >= BURST);

    // A beat in ACK is the controller accepting and consuming in one cycle.
    assign beat = ((state_q == S_ACK) && mem_ack && mem_data_next) ||
                  ((state_q == S_DATA) && mem_data_next);

    assign fifo_rd = (((state_q == S_HDR) || (state_q == S_ADDR) || (state_q == S_PAT)) ||
                      (beat && !fill_q)) && !fifo_empty;

    assign mem_wr_data = ((state_q == S_ACK) || (state_q == S_DATA))
                       ? (fill_q ? pat_q : fifo_data) : '0;

    assign mem_wr_req  = req_q;
    assign mem_wr_addr = addr_q;
    assign busy        = (state_q != S_IDLE);
    assign cmd_done    = (state_q == S_DONE);
    assign cmd_err     = err_q;

    ftdi_burst_counter #(
        .LEN_W (LEN_W),
        .BURST (BURST)
    ) u_counter (
        .mem_clk      (mem_clk),
        .ft_reset     (ft_reset),
        .load_i       ((state_q == S_HDR) && !fifo_empty),
        .len_i        (hdr_len),
        .beat_i       (beat),
        .last_beat_o  (last_beat),
        .last_burst_o (last_burst),
        .rem_zero_o   (rem_zero)
    );

    always_ff @(posedge mem_clk or posedge ft_reset) begin
        if (ft_reset) begin
            state_q <= S_IDLE;
            fill_q  <= 1'b0;
            addr_q  <= '0;
            pat_q   <= '0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: if (!fifo_empty) state_q <= S_HDR;
                S_HDR: begin
                    if (!fifo_empty) begin
                        fill_q <= (hdr_op == OP_FILL);
                        if (opcode_valid(hdr_op) && len_aligned) begin
                            state_q <= S_ADDR;
                        end else begin
                            // Only the header is consumed; the next word is a new header.
                            err_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_ADDR: begin
                    if (!fifo_empty) begin
                        addr_q <= fifo_data[AW-1:0];
                        if (rem_zero)    state_q <= S_DONE;
                        else if (fill_q) state_q <= S_PAT;
                        else             state_q <= S_REQ;
                    end
                end
                S_PAT: begin
                    if (!fifo_empty) begin
                        pat_q   <= fifo_data;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_idle && level_ok) begin
                        req_q   <= 1'b1;
                        state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (mem_ack) begin
                        req_q   <= 1'b0;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (mem_data_next && last_beat) begin
                        addr_q  <= addr_q + BURST_BYTES;
                        state_q <= last_burst ? S_DONE : S_REQ;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
